// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: bubble encoding, FSM states, default widths.
package fetch_pkg;

    localparam int ADDR_W_DEFAULT = 10;

    localparam logic [4:0] NOOP_OPCODE = 5'b00000;

    localparam logic [31:0] NOOP_INSTR = {NOOP_OPCODE, 27'b0};

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, instr} holding buffer that catches the word returning from memory while decode stalls.
module fetch_skid_buf
    import fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              drain,
    input  logic              clear,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic [31:0]       load_instr,
    output logic              full,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       instr
);

    logic              full_reg;
    logic [ADDR_W-1:0] pc_reg;
    logic [31:0]       instr_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            full_reg  <= 1'b0;
            pc_reg    <= '0;
            instr_reg <= NOOP_INSTR;
        end else if (load) begin
            full_reg  <= 1'b1;
            pc_reg    <= load_pc;
            instr_reg <= load_instr;
        end else if (drain) begin
            full_reg  <= 1'b0;
        end
    end

    assign full  = full_reg;
    assign pc    = pc_reg;
    assign instr = instr_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads a synchronous imem and feeds decode one word per cycle.
// Optional FETCH_PERF_EN adds perf_fetched / perf_stalls counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_in,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_rd_en,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       instr_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              instr_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stalls
`endif
);

    fetch_state_t      state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg;
    logic              inflight_reg;
    logic [ADDR_W-1:0] inflight_pc_reg;
    logic [31:0]       instr_out_reg;
    logic [ADDR_W-1:0] pc_out_reg;
    logic              valid_reg;
    logic              issue;

    logic              skid_load, skid_drain, skid_full;
    logic [ADDR_W-1:0] skid_pc;
    logic [31:0]       skid_instr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= BOOT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (redirect_valid) begin
            state_next = BOOT;
        end else begin
            case (state_reg)
                BOOT:    state_next = RUN;
                RUN:     if (stall_in)  state_next = HOLD;
                HOLD:    if (!stall_in) state_next = RUN;
                default: state_next = BOOT;
            endcase
        end
    end

    // BOOT always issues; afterwards a read is only issued when decode will take the result.
    always_comb begin
        issue = 1'b0;
        if (!rst && !redirect_valid) begin
            case (state_reg)
                BOOT:    issue = 1'b1;
                RUN:     issue = !stall_in;
                HOLD:    issue = !stall_in;
                default: issue = 1'b0;
            endcase
        end
    end

    assign imem_rd_en = issue;
    assign imem_addr  = pc_reg;

    assign skid_load  = !rst && !redirect_valid && stall_in && inflight_reg;
    assign skid_drain = !rst && !redirect_valid && !stall_in && skid_full;

    fetch_skid_buf #(
        .ADDR_W(ADDR_W)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .load       (skid_load),
        .drain      (skid_drain),
        .clear      (redirect_valid),
        .load_pc    (inflight_pc_reg),
        .load_instr (imem_rdata),
        .full       (skid_full),
        .pc         (skid_pc),
        .instr      (skid_instr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg          <= RESET_PC;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
            instr_out_reg   <= NOOP_INSTR;
            pc_out_reg      <= '0;
            valid_reg       <= 1'b0;
        end else if (redirect_valid) begin
            pc_reg        <= redirect_pc;
            inflight_reg  <= 1'b0;
            instr_out_reg <= NOOP_INSTR;
            valid_reg     <= 1'b0;
        end else begin
            if (issue) begin
                pc_reg <= pc_reg + ADDR_W'(1);
            end
            inflight_reg    <= issue;
            inflight_pc_reg <= pc_reg;
            // A stalled output holds; otherwise the skid word is older than any returning word.
            if (!stall_in) begin
                if (skid_full) begin
                    instr_out_reg <= skid_instr;
                    pc_out_reg    <= skid_pc;
                    valid_reg     <= 1'b1;
                end else if (inflight_reg) begin
                    instr_out_reg <= imem_rdata;
                    pc_out_reg    <= inflight_pc_reg;
                    valid_reg     <= 1'b1;
                end else begin
                    instr_out_reg <= NOOP_INSTR;
                    valid_reg     <= 1'b0;
                end
            end
        end
    end

    assign instr_out   = instr_out_reg;
    assign pc_out      = pc_out_reg;
    assign instr_valid = valid_reg;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_reg;
    logic [31:0] perf_stalls_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_reg <= '0;
            perf_stalls_reg  <= '0;
        end else begin
            if (valid_reg && !stall_in) begin
                perf_fetched_reg <= perf_fetched_reg + 32'd1;
            end
            if (stall_in) begin
                perf_stalls_reg <= perf_stalls_reg + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_reg;
    assign perf_stalls  = perf_stalls_reg;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stream, stall/skid, redirect, redirect+stall, PC wrap, mid-run reset.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_in = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [9:0]  redirect_pc = '0;
    logic [9:0]  imem_addr, imem_addr2;
    logic        imem_rd_en, imem_rd_en2;
    logic [31:0] imem_rdata, imem_rdata2;
    logic [31:0] instr_out, instr_out2;
    logic [9:0]  pc_out, pc_out2;
    logic        instr_valid, instr_valid2;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stalls, perf_fetched2, perf_stalls2;
`endif

    logic [31:0] imem [0:1023];
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(10), .RESET_PC(10'h000)) dut (
        .clk(clk), .rst(rst), .stall_in(stall_in),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_addr(imem_addr), .imem_rd_en(imem_rd_en), .imem_rdata(imem_rdata),
        .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_stalls(perf_stalls)
`endif
    );

    fetch_unit #(.ADDR_W(10), .RESET_PC(10'h3FE)) dut_wrap (
        .clk(clk), .rst(rst), .stall_in(1'b0),
        .redirect_valid(1'b0), .redirect_pc(10'h000),
        .imem_addr(imem_addr2), .imem_rd_en(imem_rd_en2), .imem_rdata(imem_rdata2),
        .instr_out(instr_out2), .pc_out(pc_out2), .instr_valid(instr_valid2)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched2), .perf_stalls(perf_stalls2)
`endif
    );

    always @(posedge clk) begin
        if (imem_rd_en)  imem_rdata  <= imem[imem_addr];
        if (imem_rd_en2) imem_rdata2 <= imem[imem_addr2];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
            $display("ok   %-16s obs=%0h exp=%0h", tag, obs, exp);
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) imem[i] = 32'(i + 100);

        tick(); tick(); tick();
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr_out, NOOP_INSTR);
        check("rst_pc_out", 32'(pc_out), 32'd0);
        check("rst_rd_en", 32'(imem_rd_en), 32'd0);
        check("rst_addr_wrap", 32'(imem_addr2), 32'h3FE);

        // cycle 0: reset released
        rst = 1'b0;
        #1;
        check("c0_rd_en", 32'(imem_rd_en), 32'd1);
        check("c0_addr", 32'(imem_addr), 32'd0);
        check("c0_valid", 32'(instr_valid), 32'd0);
        tick(); // c1
        check("c1_valid", 32'(instr_valid), 32'd0);
        tick(); // c2
        check("c2_instr", instr_out, 32'd100);
        check("c2_pc", 32'(pc_out), 32'd0);
        check("c2_valid", 32'(instr_valid), 32'd1);
        check("wrap_c2_pc", 32'(pc_out2), 32'h3FE);
        tick(); // c3
        check("c3_instr", instr_out, 32'd101);
        check("wrap_c3_pc", 32'(pc_out2), 32'h3FF);
        tick(); // c4: stall for three cycles
        stall_in = 1'b1;
        check("c4_instr", instr_out, 32'd102);
        check("wrap_c4_pc", 32'(pc_out2), 32'h000);
        check("wrap_c4_instr", instr_out2, 32'd100);
        tick(); // c5
        check("stall1_instr", instr_out, 32'd102);
        check("stall1_rd_en", 32'(imem_rd_en), 32'd0);
        tick(); // c6
        check("stall2_instr", instr_out, 32'd102);
        tick(); // c7: release
        stall_in = 1'b0;
        #1;
        check("rel_instr", instr_out, 32'd102);
        check("rel_rd_en", 32'(imem_rd_en), 32'd1);
        tick(); // c8
        check("post_103", instr_out, 32'd103);
        tick(); // c9
        check("post_104", instr_out, 32'd104);
        check("post_104_pc", 32'(pc_out), 32'd4);
        tick(); // c10: redirect to 0x40
        check("c10_instr", instr_out, 32'd105);
        redirect_valid = 1'b1;
        redirect_pc = 10'h040;
        tick(); // c11
        redirect_valid = 1'b0;
        #1;
        check("rd_bub1_valid", 32'(instr_valid), 32'd0);
        check("rd_bub1_instr", instr_out, NOOP_INSTR);
        check("rd_tgt_addr", 32'(imem_addr), 32'h040);
        tick(); // c12
        check("rd_bub2_valid", 32'(instr_valid), 32'd0);
        tick(); // c13
        check("rd_tgt_pc", 32'(pc_out), 32'h040);
        check("rd_tgt_instr", instr_out, 32'd164);
        tick(); // c14: stall fills the skid with 0x42
        check("rd_next_instr", instr_out, 32'd165);
        stall_in = 1'b1;
        tick(); // c15: redirect while stalled with the skid full
        check("hold_instr", instr_out, 32'd165);
        redirect_valid = 1'b1;
        redirect_pc = 10'h010;
        tick(); // c16
        redirect_valid = 1'b0;
        stall_in = 1'b0;
        #1;
        check("rs_bub1_valid", 32'(instr_valid), 32'd0);
        tick(); // c17
        check("rs_bub2_valid", 32'(instr_valid), 32'd0);
        tick(); // c18
        check("rs_tgt_pc", 32'(pc_out), 32'h010);
        check("rs_tgt_instr", instr_out, 32'd116);
        tick(); // c19: reset mid-stream
        check("rs_next_instr", instr_out, 32'd117);
        rst = 1'b1;
        stall_in = 1'b1;
        redirect_valid = 1'b1;
        tick();
        stall_in = 1'b0;
        redirect_valid = 1'b0;
        #1;
        check("mrst_valid", 32'(instr_valid), 32'd0);
        check("mrst_pc_out", 32'(pc_out), 32'd0);
        check("mrst_addr", 32'(imem_addr), 32'd0);
        check("mrst_rd_en", 32'(imem_rd_en), 32'd0);
`ifdef FETCH_PERF_EN
        check("mrst_perf_f", perf_fetched, 32'd0);
        check("mrst_perf_s", perf_stalls, 32'd0);
`endif
        tick();
        rst = 1'b0; // new cycle 0
        tick(); tick(); // c2
        check("re_c2_instr", instr_out, 32'd100);
        check("re_c2_valid", 32'(instr_valid), 32'd1);
`ifdef FETCH_PERF_EN
        for (int c = 3; c <= 11; c++) tick(); // c2..c11 are ten valid unstalled cycles
        tick(); // c12
        stall_in = 1'b1;
        tick(); tick(); tick(); // c15 is the fourth stall cycle
        tick(); // c16
        stall_in = 1'b0;
        #1;
        check("perf_fetched", perf_fetched, 32'd10);
        check("perf_stalls", perf_stalls, 32'd4);
        rst = 1'b1;
        tick();
        check("perf_f_clr", perf_fetched, 32'd0);
        check("perf_s_clr", perf_stalls, 32'd0);
        rst = 1'b0;
`endif
        tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of `decode`. Owns the program counter, drives a synchronous-read instruction memory, and delivers one 32-bit instruction per cycle, with its PC and a valid flag, into decode's `instruction` input. Supports a decode-side stall through a 1-entry skid buffer, and a redirect (jump/branch) input that squashes in-flight fetches and injects NOOP bubbles.

## Interface
Parameters:
- ADDR_W, 10, PC / instruction-memory word-address width
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- stall_in  in  1  downstream cannot accept a new instruction this cycle
- redirect_valid  in  1  load redirect_pc as the next fetch address
- redirect_pc  in  ADDR_W  redirect target word address
- imem_addr  out  ADDR_W  instruction memory read address
- imem_rd_en  out  1  instruction memory read enable
- imem_rdata  in  32  read data, valid exactly 1 cycle after an enabled read
- instr_out  out  32  instruction to decode; NOOP_INSTR when instr_valid=0
- pc_out  out  ADDR_W  address of instr_out
- instr_valid  out  1  instr_out holds a real fetched instruction

## Operation
- Reset values: pc=RESET_PC, imem_rd_en=0, imem_addr=RESET_PC, instr_out=NOOP_INSTR ({`NOOP, 27'b0}), pc_out=0, instr_valid=0, skid empty, inflight=0, perf counters 0.
- States: BOOT (first cycle after rst low), RUN, HOLD (stall_in=1, skid occupied or read suppressed).
- BOOT -> RUN: issue read at pc, then pc<=pc+1.
- RUN, no stall: issue read at pc each cycle, pc<=pc+1; returning word goes to instr_out with pc_out = its issue address, instr_valid=1.
- RUN, stall_in=1: hold instr_out/pc_out/instr_valid; imem_rd_en=0; pc holds; the word returning this cycle (if inflight) is captured into the skid -> HOLD.
- HOLD, stall_in=1: everything holds; no read.
- HOLD, stall_in=0: skid word (if any) drives instr_out next edge; the read at pc is issued in the same cycle -> RUN. No instruction is lost or duplicated.
- Redirect (priority over stall): pc<=redirect_pc, skid cleared, the inflight word is squashed, instr_out<=NOOP_INSTR, instr_valid<=0 at next edge; state -> BOOT.
- PC arithmetic is modulo 2^ADDR_W: pc=2^ADDR_W-1 increments to 0.
- rst asserted mid-operation: reset values at next edge regardless of stall/redirect; the returning inflight word is dropped.

## Timing
- Throughput: 1 instruction/cycle when unstalled.
- Latency: read issued cycle t -> imem_rdata in t+1 -> instr_out/instr_valid visible in t+2.
- After rst deasserts in cycle 0: imem_rd_en=1 with addr RESET_PC in cycle 0; first valid instr_out in cycle 2.
- Redirect sampled in cycle t: bubble (instr_valid=0) in t+1 and t+2; target read issued in t+1; target on instr_out in t+3.
- Stall sampled in cycle t: instr_out is unchanged at t+1; release sampled in cycle u: the next instruction appears at u+1.

## Configuration
- FETCH_PERF_EN defined: adds outputs perf_fetched (32 bits, count of cycles with instr_valid=1 and stall_in=0) and perf_stalls (32 bits, count of cycles with stall_in=1). Both wrap, and both are cleared by rst.
- FETCH_PERF_EN undefined: neither port nor counter exists; behaviour is otherwise identical.

## Structure
- Package fetch_pkg: NOOP_INSTR constant, fetch state enum (BOOT/RUN/HOLD), default ADDR_W. Opcode values come from opcodes.h.
- Sub-module fetch_skid_buf: 1-entry buffer of {pc, instr} with load, drain, clear, and full signals.

## Test plan
- Reset, then release with RESET_PC=0 and imem[i]=i+100 -> cycle 2: instr_out=100, pc_out=0, instr_valid=1; then 101, 102, ... one per cycle.
- stall_in high for 3 cycles while instr_out=102 -> 102 is held 3 cycles, then the output continues 103, 104 with no gap or repeat.
- redirect_valid with redirect_pc=0x40 while streaming -> two cycles of NOOP_INSTR/instr_valid=0, then pc_out=0x40 and instr_out=imem[0x40].
- Redirect and stall asserted in the same cycle -> the redirect wins, the skid is cleared, and the target appears 3 cycles later once the stall is released.
- RESET_PC=0x3FE, ADDR_W=10 -> pc_out sequence 0x3FE, 0x3FF, 0x000.
- With FETCH_PERF_EN: 10 unstalled valid cycles and 4 stall cycles -> perf_fetched=10 and perf_stalls=4; rst clears both to 0.
